sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter in front of the single SDRAM controller slave port.
//  Lets a reader master (e.g. min/max scanner) and a writer master share the SDRAM.
//  Round-robin grant, bounded hold time, in-order routing of pipelined read data.
// PARAMETERS
//  ADDR_W       32  address width, all ports
//  DATA_W       16  data width; byteenable is DATA_W/8 bits
//  MAX_PENDING  8   max outstanding reads (owner-FIFO depth, power of 2, >=2)
//  MAX_HOLD     16  accepted transfers after which the grant yields to a waiting peer
// PORTS  (N = 0,1; one set of mN_ ports per requester)
//  clk               in   1        system clock, all logic on rising edge
//  reset_n           in   1        synchronous active-low reset
//  mN_read_n         in   1        requester read strobe, active low
//  mN_write_n        in   1        requester write strobe, active low
//  mN_address        in   ADDR_W   requester address
//  mN_byteenable     in   DATA_W/8 requester byte enables
//  mN_writedata      in   DATA_W   requester write data
//  mN_waitrequest    out  1        stall to requester N
//  mN_readdatavalid  out  1        read data valid to requester N
//  mN_readdata       out  DATA_W   read data (s_readdata fanned out to both ports)
//  s_read_n          out  1        to SDRAM controller, active low
//  s_write_n         out  1        to SDRAM controller, active low
//  s_chipselect      out  1        high whenever a grant is held
//  s_address         out  ADDR_W   muxed address
//  s_byteenable      out  DATA_W/8 muxed byte enables
//  s_writedata       out  DATA_W   muxed write data
//  s_waitrequest     in   1        controller stall
//  s_readdatavalid   in   1        controller read data valid
//  s_readdata        in   DATA_W   controller read data
//  grant             out  2        one-hot current owner (00 = idle)
//  rd_err            out  1        sticky: readdatavalid arrived with owner FIFO empty
// BEHAVIOUR
//  Request: reqN = ~mN_read_n | ~mN_write_n. Both strobes low at once is illegal; treat as read.
//  FSM IDLE/GRANT0/GRANT1, registered. reset -> IDLE, last_grant=1 (port 0 wins first tie).
//  IDLE: one req -> grant it; both -> grant ~last_grant. Grant takes effect next cycle.
//  GRANTn: leave when reqn=0 (to other port if requesting, else IDLE), or when
//   hold_cnt==MAX_HOLD and peer requests: switch after the current transfer is accepted.
//  hold_cnt: cleared on grant entry; +1 per accepted transfer (strobe low & ~mN_waitrequest).
//  Slave mux is combinational from the grant register; in IDLE: s_read_n=s_write_n=1,
//   s_chipselect=0, s_address/s_writedata=0, s_byteenable=all ones.
//  mN_waitrequest = 1 when not granted; when granted = s_waitrequest | (read & fifo_full).
//   If fifo_full, s_read_n is held 1 (no read issued).
//  Owner FIFO: push port ID on each accepted read; pop on s_readdatavalid; head selects
//   which mN_readdatavalid pulses (same cycle, zero latency). Push+pop same cycle: count
//   unchanged. Grant may switch with reads outstanding; data still routes in issue order.
//  s_readdatavalid with FIFO empty: both mN_readdatavalid stay 0, rd_err set until reset.
//  Writes never enter the FIFO.
//  Reset outputs: grant=00, rd_err=0, mN_readdatavalid=0, mN_waitrequest=1, slave idle values.
//  Reset mid-transfer: FIFO and hold_cnt cleared, next cycle IDLE; late readdatavalid -> rd_err.
// TESTING
//  1 m0 reads addr 0..9, m1 idle -> grant=01, 10 pulses on m0_readdatavalid, none on m1.
//  2 both request 1st cycle after reset -> grant 01 first; m0 releases -> 10 next cycle.
//  3 MAX_HOLD=4, m0 streams writes, m1 waits -> 4 m0 writes accepted, then grant=10.
//  4 MAX_PENDING=4, slave withholds readdatavalid -> 5th m0 read sees waitrequest=1, s_read_n=1.
//  5 m0 issues 2 reads, m1 then 1 read, slave returns 3 -> routed m0,m0,m1 in order.
//  6 reset_n=0 mid-burst with 3 outstanding -> grant=00 next cycle; late valid sets rd_err=1.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter for one SDRAM controller port: round-robin grant with bounded
// hold time, and an owner FIFO that routes pipelined read data back in issue order.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // requester 0
  input  logic                  m0_read_n,
  input  logic                  m0_write_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic                  m0_readdatavalid,
  output logic [DATA_W-1:0]     m0_readdata,
  // requester 1
  input  logic                  m1_read_n,
  input  logic                  m1_write_n,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic                  m1_readdatavalid,
  output logic [DATA_W-1:0]     m1_readdata,
  // SDRAM controller slave
  output logic                  s_read_n,
  output logic                  s_write_n,
  output logic                  s_chipselect,
  output logic [ADDR_W-1:0]     s_address,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [DATA_W-1:0]     s_writedata,
  input  logic                  s_waitrequest,
  input  logic                  s_readdatavalid,
  input  logic [DATA_W-1:0]     s_readdata,
  // status
  output logic [1:0]            grant,
  output logic                  rd_err
);

  localparam int unsigned PTR_W  = $clog2(MAX_PENDING);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [HOLD_W-1:0] HoldMax  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(MAX_PENDING);

  // State encoding doubles as the one-hot grant output.
  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StGrant0 = 2'b01;
  localparam logic [1:0] StGrant1 = 2'b10;

  logic [1:0]             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [MAX_PENDING-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rd_err_q, rd_err_d;

  logic req0, req1, rd0, rd1, wr0, wr1;
  logic own0, own1, acc0, acc1;
  logic fifo_full, fifo_empty, push, pop, head;
  logic own_req, own_acc, peer_req;
  logic [1:0] peer_st;

  // Both strobes low is illegal and decodes as a read.
  assign req0 = ~m0_read_n | ~m0_write_n;
  assign req1 = ~m1_read_n | ~m1_write_n;
  assign rd0  = ~m0_read_n;
  assign rd1  = ~m1_read_n;
  assign wr0  = m0_read_n & ~m0_write_n;
  assign wr1  = m1_read_n & ~m1_write_n;

  assign own0 = (state_q == StGrant0);
  assign own1 = (state_q == StGrant1);

  assign fifo_full  = (cnt_q == CntFull);
  assign fifo_empty = (cnt_q == '0);

  assign m0_waitrequest = own0 ? (s_waitrequest | (rd0 & fifo_full)) : 1'b1;
  assign m1_waitrequest = own1 ? (s_waitrequest | (rd1 & fifo_full)) : 1'b1;

  assign acc0 = own0 & req0 & ~m0_waitrequest;
  assign acc1 = own1 & req1 & ~m1_waitrequest;

  always_comb begin
    s_read_n     = 1'b1;
    s_write_n    = 1'b1;
    s_chipselect = 1'b0;
    s_address    = '0;
    s_byteenable = '1;
    s_writedata  = '0;
    unique case (state_q)
      StGrant0: begin
        s_read_n     = ~(rd0 & ~fifo_full);
        s_write_n    = ~wr0;
        s_chipselect = 1'b1;
        s_address    = m0_address;
        s_byteenable = m0_byteenable;
        s_writedata  = m0_writedata;
      end
      StGrant1: begin
        s_read_n     = ~(rd1 & ~fifo_full);
        s_write_n    = ~wr1;
        s_chipselect = 1'b1;
        s_address    = m1_address;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  always_comb begin
    own_req  = 1'b0;
    own_acc  = 1'b0;
    peer_req = 1'b0;
    peer_st  = StIdle;
    unique case (state_q)
      StGrant0: begin
        own_req  = req0;
        own_acc  = acc0;
        peer_req = req1;
        peer_st  = StGrant1;
      end
      StGrant1: begin
        own_req  = req1;
        own_acc  = acc1;
        peer_req = req0;
        peer_st  = StGrant0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        // Yield on release, or once the hold budget is spent and the peer is waiting.
        if (!own_req || (peer_req && own_acc && hold_cnt_q >= HoldLast)) begin
          state_d = peer_req ? peer_st : StIdle;
        end else if (own_acc && hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q && state_d != StIdle) begin
      hold_cnt_d   = '0;
      last_grant_d = (state_d == StGrant1);
    end
  end

  assign push = (acc0 & rd0) | (acc1 & rd1);
  assign pop  = s_readdatavalid & ~fifo_empty;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_err_d = rd_err_q | (s_readdatavalid & fifo_empty);
    if (push) begin
      mem_d[wr_ptr_q] = own1;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign grant            = state_q;
  assign rd_err           = rd_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rd_err_q     <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: queued master transactions, a queued SDRAM slave model and a
// global issue-order scoreboard for read-data routing.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned MP     = 4;
  localparam int unsigned MH     = 4;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } op_t;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } ord_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0_read_n, m0_write_n, m1_read_n, m1_write_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic s_read_n, s_write_n, s_chipselect, s_waitrequest, s_readdatavalid;
  logic [1:0] grant;
  logic rd_err;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MP), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read_n(m0_read_n), .m0_write_n(m0_write_n), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_readdata(m0_readdata),
    .m1_read_n(m1_read_n), .m1_write_n(m1_write_n), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata),
    .s_read_n(s_read_n), .s_write_n(s_write_n), .s_chipselect(s_chipselect),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .grant(grant), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  op_t         q0[$], q1[$];
  ord_t        order_q[$];
  logic [31:0] slave_q[$];
  int          rdv_log[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int rdv0_cnt, rdv1_cnt, wr0_cnt;
  logic stall_en = 1'b0, pace_en = 1'b0, withhold = 1'b0, exp_rd_err = 1'b0;
  logic [1:0] grant_after_rst;
  logic l_m0_wait, l_m1_wait, l_s_read_n, l_s_write_n, l_cs;
  logic [1:0] l_be, l_grant, l_rdv;
  logic [31:0] l_addr;
  logic [15:0] l_wdata;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    m0_read_n = 1'b1; m0_write_n = 1'b1; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read_n = 1'b1; m1_write_n = 1'b1; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    if (q0.size() > 0) begin
      m0_read_n = q0[0].wr; m0_write_n = !q0[0].wr; m0_address = q0[0].addr;
      m0_byteenable = q0[0].be; m0_writedata = q0[0].data;
    end
    if (q1.size() > 0) begin
      m1_read_n = q1[0].wr; m1_write_n = !q1[0].wr; m1_address = q1[0].addr;
      m1_byteenable = q1[0].be; m1_writedata = q1[0].data;
    end
  endtask

  // One clock: sample and check at negedge, update models and drive inputs 1ns after posedge.
  task automatic step();
    logic a0, a1, sacc, srd, orphan, rst_seen;
    logic [31:0] saddr;
    op_t op;
    ord_t ord;
    @(negedge clk);
    l_grant = grant; l_m0_wait = m0_waitrequest; l_m1_wait = m1_waitrequest;
    l_s_read_n = s_read_n; l_s_write_n = s_write_n; l_cs = s_chipselect; l_be = s_byteenable;
    l_addr = s_address; l_wdata = s_writedata; l_rdv = {m1_readdatavalid, m0_readdatavalid};
    a0 = (q0.size() > 0) && !m0_waitrequest;
    a1 = (q1.size() > 0) && !m1_waitrequest;
    sacc = s_chipselect && (!s_read_n || !s_write_n) && !s_waitrequest;
    srd = !s_read_n;
    saddr = s_address;
    orphan = 1'b0;
    if (a0 || a1 || sacc) begin
      check("bus_accept", sacc, a0 | a1);
      check("one_owner", a0 & a1, 1'b0);
      if (sacc && (a0 || a1)) begin
        op = a0 ? q0[0] : q1[0];
        check("bus_addr", s_address, op.addr);
        check("bus_dir", srd, !op.wr);
        if (op.wr) check("bus_wdata", {s_byteenable, s_writedata}, {op.be, op.data});
      end
    end
    if (m0_readdatavalid) begin rdv0_cnt++; rdv_log.push_back(0); end
    if (m1_readdatavalid) begin rdv1_cnt++; rdv_log.push_back(1); end
    if (s_readdatavalid) begin
      if (order_q.size() > 0) begin
        ord = order_q.pop_front();
        check("rdv_route", l_rdv, ord.port ? 2'b10 : 2'b01);
        check("rdv_data", ord.port ? m1_readdata : m0_readdata, ord.data);
      end else begin
        check("rdv_orphan", l_rdv, 2'b00);
        orphan = 1'b1;
      end
    end else begin
      check("rdv_idle", l_rdv, 2'b00);
    end
    check("rd_err", rd_err, exp_rd_err);
    @(posedge clk);
    rst_seen = !reset_n;
    #1;
    if (s_readdatavalid && slave_q.size() > 0) void'(slave_q.pop_front());
    if (sacc && srd) slave_q.push_back(saddr);
    if (a0) begin
      op = q0.pop_front();
      if (op.wr) wr0_cnt++;
      else order_q.push_back('{port: 1'b0, data: mem_f(op.addr)});
    end
    if (a1) begin
      op = q1.pop_front();
      if (!op.wr) order_q.push_back('{port: 1'b1, data: mem_f(op.addr)});
    end
    if (orphan) exp_rd_err = 1'b1;
    if (rst_seen) begin
      order_q.delete();
      exp_rd_err = 1'b0;
    end
    drive_pins();
    s_waitrequest = stall_en && ($urandom_range(0, 3) == 0);
    s_readdatavalid = !withhold && (slave_q.size() > 0) && (!pace_en || $urandom_range(0, 1) == 1);
    s_readdata = s_readdatavalid ? mem_f(slave_q[0]) : 16'($urandom);
  endtask

  task automatic do_reset();
    logic wh;
    wh = withhold;
    withhold = 1'b1;
    q0.delete(); q1.delete();
    drive_pins();
    s_readdatavalid = 1'b0;
    reset_n = 1'b0;
    step();
    grant_after_rst = grant;
    step();
    reset_n = 1'b1;
    withhold = wh;
    rdv0_cnt = 0; rdv1_cnt = 0; wr0_cnt = 0;
    rdv_log.delete();
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + order_q.size() + slave_q.size()) > 0 && n < bound) begin
      step();
      n++;
    end
    check(tag, (q0.size() + q1.size() + order_q.size() + slave_q.size()) == 0, 1'b1);
  endtask

  function automatic op_t mk(input logic wr, input logic [31:0] a);
    return '{wr: wr, addr: a, data: 16'($urandom), be: 2'($urandom)};
  endfunction

  initial begin
    int n;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    drive_pins();
    do_reset();

    // Reset values
    step();
    check("rst_grant", l_grant, 2'b00);
    check("rst_m0_wait", l_m0_wait, 1'b1);
    check("rst_m1_wait", l_m1_wait, 1'b1);
    check("rst_s_read_n", l_s_read_n, 1'b1);
    check("rst_s_write_n", l_s_write_n, 1'b1);
    check("rst_cs", l_cs, 1'b0);
    check("rst_be", l_be, 2'b11);
    check("rst_addr", l_addr, 32'h0);
    check("rst_wdata", l_wdata, 16'h0);

    // 1: m0 reads 0..9 alone, with stalls and paced returns
    stall_en = 1'b1; pace_en = 1'b1;
    for (int i = 0; i < 10; i++) q0.push_back(mk(1'b0, 32'(i)));
    step();
    check("t1_idle", grant, 2'b00);
    step();
    check("t1_grant", grant, 2'b01);
    drain("t1_drain", 300);
    check("t1_rdv0", rdv0_cnt, 10);
    check("t1_rdv1", rdv1_cnt, 0);

    // 2: simultaneous first requests after reset
    stall_en = 1'b0; pace_en = 1'b0;
    do_reset();
    q0.push_back(mk(1'b1, 32'h10));
    q1.push_back(mk(1'b1, 32'h20));
    step();
    step();
    check("t2_first", grant, 2'b01);
    n = 0;
    while (q0.size() > 0 && n < 20) begin step(); n++; end
    step();
    check("t2_switch", grant, 2'b10);
    drain("t2_drain", 50);

    // 3: hold limit while m1 waits
    do_reset();
    for (int i = 0; i < 8; i++) q0.push_back(mk(1'b1, 32'h100 + 32'(i)));
    q1.push_back(mk(1'b1, 32'h200));
    n = 0;
    while (grant != 2'b10 && n < 50) begin step(); n++; end
    check("t3_writes_before_yield", wr0_cnt, 4);
    check("t3_grant", grant, 2'b10);
    drain("t3_drain", 100);

    // 4: owner FIFO full blocks the fifth read
    do_reset();
    withhold = 1'b1;
    for (int i = 0; i < 5; i++) q0.push_back(mk(1'b0, 32'h300 + 32'(i)));
    n = 0;
    while (order_q.size() < 4 && n < 30) begin step(); n++; end
    check("t4_outstanding", order_q.size(), 4);
    step();
    check("t4_wait", l_m0_wait, 1'b1);
    check("t4_s_read_n", l_s_read_n, 1'b1);
    withhold = 1'b0;
    drain("t4_drain", 100);

    // 5: in-order routing across a grant switch
    do_reset();
    withhold = 1'b1;
    q0.push_back(mk(1'b0, 32'h400));
    q0.push_back(mk(1'b0, 32'h401));
    q1.push_back(mk(1'b0, 32'h500));
    n = 0;
    while (order_q.size() < 3 && n < 30) begin step(); n++; end
    withhold = 1'b0;
    drain("t5_drain", 100);
    check("t5_count", rdv_log.size(), 3);
    if (rdv_log.size() == 3) begin
      check("t5_order0", rdv_log[0], 0);
      check("t5_order1", rdv_log[1], 0);
      check("t5_order2", rdv_log[2], 1);
    end

    // 6: reset with reads outstanding, late data flags rd_err
    do_reset();
    withhold = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(mk(1'b0, 32'h600 + 32'(i)));
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, 32'h700 + 32'(i)));
    n = 0;
    while (order_q.size() < 3 && n < 30) begin step(); n++; end
    check("t6_pre_grant", grant, 2'b01);
    do_reset();
    check("t6_grant_after_reset", grant_after_rst, 2'b00);
    check("t6_slave_pending", slave_q.size(), 3);
    withhold = 1'b0;
    drain("t6_drain", 50);
    step();
    check("t6_rd_err", rd_err, 1'b1);
    check("t6_no_rdv", rdv0_cnt + rdv1_cnt, 0);

    // 7: random mixed traffic from both masters
    do_reset();
    stall_en = 1'b1; pace_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      q0.push_back(mk(1'($urandom), $urandom));
      q1.push_back(mk(1'($urandom), $urandom));
    end
    drain("t7_drain", 3000);
    step();
    check("t7_rd_err", rd_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
